seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/seq_detector_param_sat_counter.sv | 30 +++
 rtl/seq_detector_param.sv | 117 +++++++++++
 tb/tb_seq_detector_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
// Holds the reset-default configuration and the legal MAX_LEN range.
package seq_det_pkg;

    localparam int MAX_LEN_MIN = 2;
    localparam int MAX_LEN_LIM = 32;

    localparam logic [2:0] DEF_PAT = 3'b101;
    localparam int         DEF_LEN = 3;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } det_mode_e;

    localparam det_mode_e DEF_MODE = MODE_OVL;

    // A pattern length is unusable when zero or longer than the history can hold.
    function automatic logic len_bad(input logic [5:0] len, input logic [5:0] max_len);
        return (len == 6'd0) || (len > max_len);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter: clears on rst or clr, increments on inc,
// and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Count register with clear priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (clr) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != {W{1'b1}})) begin
            q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping mode, Mealy and registered match flags.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               in_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_q_r;
    logic [LEN_W-1:0]   len_q_r;
    det_mode_e          overlap_q_r;
    logic               cfg_err_r;

    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic               z_q_r;

    logic               accept_s;
    logic               match_s;
    logic               z_s;
    logic [MAX_LEN:0]   window_s;
    logic [MAX_LEN:0]   mask_s;
    logic [LEN_W-1:0]   len_m1_s;
    logic [LEN_W-1:0]   fill_inc_s;

    // Match evaluation: newest bit x sits at window bit 0, so the low len_q
    // bits of {hist, x} line up with pat_q[len_q-1:0].
    always_comb begin
        accept_s = in_valid & ~load & ~rst;
        window_s = {hist_r, x};
        for (int i = 0; i <= MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_q_r));
        end
        len_m1_s   = len_q_r - LEN_W'(1);
        match_s    = ((((window_s ^ {1'b0, pat_q_r}) & mask_s) == {(MAX_LEN+1){1'b0}})
                      && (fill_r >= len_m1_s));
        z_s        = accept_s & ~cfg_err_r & match_s;
        if (fill_r == LEN_W'(MAX_LEN)) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + LEN_W'(1);
        end
    end

    // Configuration registers; cfg_err always tracks the length currently held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q_r     <= MAX_LEN'(DEF_PAT);
            len_q_r     <= LEN_W'(DEF_LEN);
            overlap_q_r <= DEF_MODE;
            cfg_err_r   <= 1'b0;
        end else if (load) begin
            pat_q_r     <= pat;
            len_q_r     <= pat_len;
            overlap_q_r <= det_mode_e'(overlap);
            cfg_err_r   <= len_bad(6'(pat_len), 6'(MAX_LEN));
        end else begin
            pat_q_r     <= pat_q_r;
            len_q_r     <= len_q_r;
            overlap_q_r <= overlap_q_r;
            cfg_err_r   <= len_bad(6'(len_q_r), 6'(MAX_LEN));
        end
    end

    // History, fill level and registered match flag.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= LEN_W'(0);
            z_q_r  <= 1'b0;
        end else begin
            z_q_r <= z_s;
            if (accept_s) begin
                hist_r <= {hist_r[MAX_LEN-2:0], x};
                // Non-overlapping mode forgets every bit that took part in a match.
                if (z_s && (overlap_q_r == MODE_NONOVL)) begin
                    fill_r <= LEN_W'(0);
                end else begin
                    fill_r <= fill_inc_s;
                end
            end else begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .inc (z_s),
        .q   (match_cnt)
    );

    assign z       = z_s;
    assign z_q     = z_q_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default instance plus a CNT_W=2
// instance sharing the same stimulus for the counter saturation case.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       x;
    logic       in_valid;
    logic       load;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       overlap;

    logic       z;
    logic       z_q;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       z2;
    logic       z_q2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;

    int checks = 0;
    int errors = 0;

    seq_detector_param dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .load      (load),
        .pat       (pat),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .z         (z),
        .z_q       (z_q),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .load      (load),
        .pat       (pat),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .z         (z2),
        .z_q       (z_q2),
        .match_cnt (match_cnt2),
        .cfg_err   (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One serial bit: z checked before the edge, z_q and count after it.
    task automatic step(input logic xv, input logic vv, input logic ez, input logic [7:0] ecnt);
        @(negedge clk);
        rst      = 1'b0;
        load     = 1'b0;
        x        = xv;
        in_valid = vv;
        #1;
        chk("z", 32'(z), 32'(ez));
        @(posedge clk);
        #1;
        chk("z_q", 32'(z_q), 32'(ez));
        chk("match_cnt", 32'(match_cnt), 32'(ecnt));
    endtask

    // Load with a valid 1 presented in the same cycle; the bit must be dropped.
    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
        @(negedge clk);
        rst      = 1'b0;
        load     = 1'b1;
        pat      = p;
        pat_len  = l;
        overlap  = o;
        x        = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("z_on_load", 32'(z), 32'd0);
        @(posedge clk);
        #1;
        chk("z_q_after_load", 32'(z_q), 32'd0);
        chk("cnt_after_load", 32'(match_cnt), 32'd0);
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst      = 1'b1;
        load     = 1'b0;
        x        = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("z_in_rst", 32'(z), 32'd0);
        @(posedge clk);
        #1;
        chk("z_q_after_rst", 32'(z_q), 32'd0);
        chk("cnt_after_rst", 32'(match_cnt), 32'd0);
        chk("cfg_err_after_rst", 32'(cfg_err), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        x        = 1'b0;
        in_valid = 1'b0;
        load     = 1'b0;
        pat      = 8'h00;
        pat_len  = 4'd0;
        overlap  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_z", 32'(z), 32'd0);
        chk("reset_z_q", 32'(z_q), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        chk("reset_cnt2", 32'(match_cnt2), 32'd0);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);

        // Reset defaults: 101, overlapping
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd1);
        step(1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b1, 1'b1, 8'd2);

        // 101 non-overlapping
        do_load(8'h05, 4'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd1);
        step(1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b1, 1'b0, 8'd1);

        // Full-length pattern with an in_valid gap
        do_load(8'b11010011, 4'd8, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd1);

        // Reset mid-sequence discards the partial match
        do_load(8'h05, 4'd3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        do_rst();
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd1);

        // Illegal lengths
        do_load(8'h05, 4'd0, 1'b1);
        chk("cfg_err_len0", 32'(cfg_err), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        chk("cfg_err_len0_hold", 32'(cfg_err), 32'd1);
        do_load(8'h05, 4'd9, 1'b1);
        chk("cfg_err_len9", 32'(cfg_err), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        do_load(8'h05, 4'd3, 1'b1);
        chk("cfg_err_cleared", 32'(cfg_err), 32'd0);

        // Config inputs must be ignored without load
        pat     = 8'h00;
        pat_len = 4'd1;
        overlap = 1'b0;
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'd1);
        step(1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b1, 1'b1, 8'd2);

        // Length-1 pattern; the CNT_W=2 instance saturates at 3
        do_load(8'h01, 4'd1, 1'b1);
        chk("cnt2_after_load", 32'(match_cnt2), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(i + 1));
            chk("cnt2_sat", 32'(match_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
